gsim_solver: RTL and testbench

Parametrised Gauss-Seidel solver for the banded Toeplitz system 20·x_i − 13(x_{i−1}+x_{i+1}) + 6(x_{i−2}+x_{i+2}) − (x_{i−3}+x_{i+3}) = b_i. Neighbours with indices outside 0..N−1 contribute zero.
- Generalises the fixed 16-point solver: vector length, widths and coefficients are parameters.
- Iteration limit and convergence tolerance are run-time inputs, with early termination.
- Input and output use valid/ready handshakes with backpressure.
- Sits between the b-vector source and the result consumer, and accepts back-to-back problems.

---
 rtl/gsim_if.sv | 28 ++
 rtl/gsim_solver.sv | 179 +++++++++++++++++
 tb/tb_gsim_solver.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gsim_if.sv
// gsim_if: b-vector input and x-vector output handshakes of the Gauss-Seidel solver
interface gsim_if #(
  parameter int B_W = 16,
  parameter int FRAC_W = 16,
  parameter int ITER_W = 7
);
  localparam int X_W = B_W + FRAC_W;
  logic in_valid;
  logic in_ready;
  logic signed [B_W-1:0] b_in;
  logic [ITER_W-1:0] iter_limit;
  logic [X_W-1:0] tol;
  logic out_valid;
  logic out_ready;
  logic signed [X_W-1:0] x_out;
  logic out_last;
  logic busy;
  logic converged;
  logic [ITER_W-1:0] iter_count;
  modport master (
    output in_valid, b_in, iter_limit, tol, out_ready,
    input in_ready, out_valid, x_out, out_last, busy, converged, iter_count
  );
  modport slave (
    input in_valid, b_in, iter_limit, tol, out_ready,
    output in_ready, out_valid, x_out, out_last, busy, converged, iter_count
  );
endinterface

// File: rtl/gsim_solver.sv
// gsim_solver: Gauss-Seidel solver for a 7-band Toeplitz system with early termination
module gsim_solver #(
  parameter int N = 16,
  parameter int B_W = 16,
  parameter int FRAC_W = 16,
  parameter int ITER_W = 7,
  parameter int DIAG = 20,
  parameter int C1 = 13,
  parameter int C2 = 6,
  parameter int C3 = 1
) (
  input logic clk,
  input logic reset,
  gsim_if.slave io
);
  localparam int X_W = B_W + FRAC_W;
  localparam int AW = X_W + 6;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic signed [AW-1:0] DIV = AW'(DIAG);
  localparam logic signed [AW-1:0] K1 = AW'(C1);
  localparam logic signed [AW-1:0] K2 = AW'(C2);
  localparam logic signed [AW-1:0] K3 = AW'(C3);
  localparam logic signed [AW-1:0] XMAX = {{(AW-X_W+1){1'b0}}, {(X_W-1){1'b1}}};
  localparam logic signed [AW-1:0] XMIN = ~XMAX;

  typedef enum logic [1:0] {LOAD, SOLVE, OUTPUT} state_t;
  state_t state;
  logic signed [X_W-1:0] x [N];
  logic signed [B_W-1:0] b [N];
  logic [IW-1:0] idx, lk, k;
  logic ph;
  logic signed [AW-1:0] acc;
  logic [X_W:0] maxd;
  logic [ITER_W-1:0] lim_r, iter_count;
  logic [X_W-1:0] tol_r;
  logic converged, out_valid, out_last;
  logic signed [X_W-1:0] x_out;

  logic signed [X_W-1:0] xm1, xp1, xm2, xp2, xm3, xp3, x_old, q_sat;
  logic signed [B_W-1:0] b_cur;
  logic signed [AW-1:0] acc_next, q;
  logic [X_W:0] dx, ad, mx;
  logic [ITER_W-1:0] ic_next;
  logic done_tol;

  assign io.in_ready = state == LOAD;
  assign io.busy = state != LOAD;
  assign io.out_valid = out_valid;
  assign io.x_out = x_out;
  assign io.out_last = out_last;
  assign io.converged = converged;
  assign io.iter_count = iter_count;

  // Neighbour gather (out-of-range neighbours read as zero), weighted sum, divide, saturate and delta
  always_comb begin
    xm1 = '0;
    xp1 = '0;
    xm2 = '0;
    xp2 = '0;
    xm3 = '0;
    xp3 = '0;
    x_old = '0;
    b_cur = '0;
    for (int j = 0; j < N; j++) begin
      if (j == int'(idx) - 1) xm1 = x[j];
      if (j == int'(idx) + 1) xp1 = x[j];
      if (j == int'(idx) - 2) xm2 = x[j];
      if (j == int'(idx) + 2) xp2 = x[j];
      if (j == int'(idx) - 3) xm3 = x[j];
      if (j == int'(idx) + 3) xp3 = x[j];
      if (j == int'(idx)) begin
        x_old = x[j];
        b_cur = b[j];
      end
    end
    acc_next = $signed({{(AW-X_W){b_cur[B_W-1]}}, b_cur, {FRAC_W{1'b0}}})
             + K1 * (AW'(xm1) + AW'(xp1))
             - K2 * (AW'(xm2) + AW'(xp2))
             + K3 * (AW'(xm3) + AW'(xp3));
    q = acc / DIV;
    q_sat = q > XMAX ? XMAX[X_W-1:0] : q < XMIN ? XMIN[X_W-1:0] : q[X_W-1:0];
    dx = {q_sat[X_W-1], q_sat} - {x_old[X_W-1], x_old};
    ad = dx[X_W] ? -dx : dx;
    mx = ad > maxd ? ad : maxd;
    ic_next = iter_count + 1'b1;
    done_tol = mx <= {1'b0, tol_r};
  end

  // Load / solve / output state machine; every output is registered here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD;
      idx <= '0;
      lk <= '0;
      k <= '0;
      ph <= 1'b0;
      acc <= '0;
      maxd <= '0;
      lim_r <= '0;
      tol_r <= '0;
      iter_count <= '0;
      converged <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      x_out <= '0;
      for (int j = 0; j < N; j++) begin
        x[j] <= '0;
        b[j] <= '0;
      end
    end else begin
      case (state)
        LOAD: if (io.in_valid) begin
          b[lk] <= io.b_in;
          x[lk] <= {io.b_in, {FRAC_W{1'b0}}};
          if (lk == '0) begin
            lim_r <= io.iter_limit;
            tol_r <= io.tol;
          end
          if (lk == LAST) begin
            lk <= '0;
            idx <= '0;
            ph <= 1'b0;
            maxd <= '0;
            if ((lk == '0 ? io.iter_limit : lim_r) == '0) begin
              state <= OUTPUT;
              out_valid <= 1'b1;
              k <= '0;
              out_last <= N == 1;
              x_out <= lk == '0 ? {io.b_in, {FRAC_W{1'b0}}} : x[0];
            end else begin
              state <= SOLVE;
            end
          end else begin
            lk <= lk + 1'b1;
          end
        end
        SOLVE: if (!ph) begin
          acc <= acc_next;
          ph <= 1'b1;
        end else begin
          ph <= 1'b0;
          x[idx] <= q_sat;
          if (idx == LAST) begin
            iter_count <= ic_next;
            idx <= '0;
            maxd <= '0;
            if (done_tol || ic_next == lim_r) begin
              state <= OUTPUT;
              converged <= done_tol;
              out_valid <= 1'b1;
              k <= '0;
              out_last <= N == 1;
              x_out <= N == 1 ? q_sat : x[0];
            end
          end else begin
            idx <= idx + 1'b1;
            maxd <= mx;
          end
        end
        OUTPUT: if (io.out_ready) begin
          if (out_last) begin
            state <= LOAD;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            x_out <= '0;
            iter_count <= '0;
            converged <= 1'b0;
          end else begin
            k <= k + 1'b1;
            x_out <= x[k + 1'b1];
            out_last <= k + 1'b1 == LAST;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_gsim_solver.sv
// tb_gsim_solver: scoreboard bench for N=16 and N=1 solvers against a plain-arithmetic model
module tb_gsim_solver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gsim_if #(.B_W(16), .FRAC_W(16), .ITER_W(7)) io16();
  gsim_if #(.B_W(16), .FRAC_W(16), .ITER_W(7)) io1();
  gsim_solver #(.N(16)) dut16 (.clk(clk), .reset(reset), .io(io16));
  gsim_solver #(.N(1)) dut1 (.clk(clk), .reset(reset), .io(io1));

  typedef struct {longint x; bit last; bit conv; int it;} exp_t;
  exp_t q16[$], q1[$];
  int sc16[$], sc1[$];
  int checks = 0, failures = 0;
  longint mb [0:63];
  longint mx [0:63];
  int beat16 = 0, held_n = 0;
  bit dir = 0, rnd = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference: full Gauss-Seidel sweeps on integers, neighbours outside 0..n-1 are zero
  function automatic void run_model(input int n, input int lim, input longint tolv, output bit conv, output int it);
    longint s, q, d, md;
    int j;
    conv = 0;
    it = 0;
    for (int i = 0; i < n; i++) mx[i] = mb[i] * 65536;
    for (int sw = 0; sw < lim; sw++) begin
      md = 0;
      for (int i = 0; i < n; i++) begin
        s = mb[i] * 65536;
        for (int dd = 1; dd <= 3; dd++) begin
          for (int sg = -1; sg <= 1; sg += 2) begin
            j = i + sg * dd;
            if (j >= 0 && j < n) s += (dd == 1 ? 13 : dd == 2 ? -6 : 1) * mx[j];
          end
        end
        q = s / 20;
        if (q > 64'sd2147483647) q = 64'sd2147483647;
        if (q < -64'sd2147483648) q = -64'sd2147483648;
        d = q - mx[i];
        if (d < 0) d = -d;
        if (d > md) md = d;
        mx[i] = q;
      end
      it++;
      if (md <= tolv) begin
        conv = 1;
        break;
      end
    end
  endfunction

  task automatic drive(input int sel, input bit v, input longint bv, input int lim, input longint tolv);
    if (sel == 16) begin
      io16.in_valid = v;
      io16.b_in = 16'(bv);
      io16.iter_limit = 7'(lim);
      io16.tol = 32'(tolv);
    end else begin
      io1.in_valid = v;
      io1.b_in = 16'(bv);
      io1.iter_limit = 7'(lim);
      io1.tol = 32'(tolv);
    end
  endtask

  task automatic send(input int sel, input int lim, input longint tolv);
    bit conv;
    int it, t;
    int n = sel == 16 ? 16 : 1;
    exp_t e;
    run_model(n, lim, tolv, conv, it);
    for (int i = 0; i < n; i++) begin
      e.x = mx[i];
      e.last = i == n - 1;
      e.conv = conv;
      e.it = it;
      if (sel == 16) q16.push_back(e); else q1.push_back(e);
    end
    if (sel == 16) sc16.push_back(2 * n * it); else sc1.push_back(2 * n * it);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        drive(sel, 0, $urandom, $urandom, $urandom);
        @(negedge clk);
      end
      drive(sel, 1, mb[i], i == 0 ? lim : int'($urandom), i == 0 ? tolv : longint'($urandom));
      t = 0;
      while (!(sel == 16 ? io16.in_ready : io1.in_ready) && t < 20000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20000) chk("in_ready_timeout", 0, 1);
      @(posedge clk);
    end
    @(negedge clk);
    drive(sel, 0, 0, 0, 0);
  endtask

  // Output consumers: random or directed backpressure, updated away from both edges
  always @(posedge clk) begin
    #2;
    if (dir && io16.out_valid && beat16 == 3 && held_n < 5) begin
      io16.out_ready = 1'b0;
      held_n++;
    end else begin
      io16.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    io1.out_ready = $urandom_range(0, 2) != 0;
  end

  int cnt16 = 0, cnt1 = 0;
  bit first16 = 1, first1 = 1, have16 = 0, have1 = 0;
  longint hx16, hx1;
  exp_t e16, e1;

  // Monitor for the N=16 solver
  always @(negedge clk) begin
    if (reset) begin
      cnt16 = 0;
      first16 = 1;
      have16 = 0;
      beat16 = 0;
    end else begin
      if (io16.busy && !io16.out_valid) cnt16++;
      if (have16) begin
        chk("hold_valid16", io16.out_valid, 1);
        chk("hold_x16", io16.x_out, hx16);
        have16 = 0;
      end
      if (io16.out_valid) begin
        chk("in_ready_out16", io16.in_ready, 0);
        if (first16) begin
          if (sc16.size() > 0) chk("solve_cycles16", cnt16, sc16.pop_front());
          else chk("unexpected_out16", 1, 0);
          first16 = 0;
        end
        if (io16.out_ready) begin
          if (q16.size() == 0) chk("unexpected_beat16", 1, 0);
          else begin
            e16 = q16.pop_front();
            chk("x16", io16.x_out, e16.x);
            chk("last16", io16.out_last, e16.last);
            chk("conv16", io16.converged, e16.conv);
            chk("iter16", io16.iter_count, e16.it);
          end
          beat16++;
          if (io16.out_last) begin
            first16 = 1;
            cnt16 = 0;
            beat16 = 0;
          end
        end else begin
          have16 = 1;
          hx16 = io16.x_out;
        end
      end else begin
        chk("x_idle16", io16.x_out, 0);
      end
    end
  end

  // Monitor for the N=1 solver
  always @(negedge clk) begin
    if (reset) begin
      cnt1 = 0;
      first1 = 1;
      have1 = 0;
    end else begin
      if (io1.busy && !io1.out_valid) cnt1++;
      if (have1) begin
        chk("hold_x1", io1.x_out, hx1);
        have1 = 0;
      end
      if (io1.out_valid) begin
        if (first1) begin
          if (sc1.size() > 0) chk("solve_cycles1", cnt1, sc1.pop_front());
          else chk("unexpected_out1", 1, 0);
          first1 = 0;
        end
        if (io1.out_ready) begin
          if (q1.size() == 0) chk("unexpected_beat1", 1, 0);
          else begin
            e1 = q1.pop_front();
            chk("x1", io1.x_out, e1.x);
            chk("last1", io1.out_last, e1.last);
            chk("conv1", io1.converged, e1.conv);
            chk("iter1", io1.iter_count, e1.it);
          end
          first1 = 1;
          cnt1 = 0;
        end else begin
          have1 = 1;
          hx1 = io1.x_out;
        end
      end
    end
  end

  task automatic check_idle();
    chk("rst_in_ready16", io16.in_ready, 1);
    chk("rst_out_valid16", io16.out_valid, 0);
    chk("rst_x16", io16.x_out, 0);
    chk("rst_last16", io16.out_last, 0);
    chk("rst_busy16", io16.busy, 0);
    chk("rst_conv16", io16.converged, 0);
    chk("rst_iter16", io16.iter_count, 0);
    chk("rst_in_ready1", io1.in_ready, 1);
    chk("rst_busy1", io1.busy, 0);
  endtask

  initial begin
    logic signed [15:0] r;
    int t;
    drive(16, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_idle();
    #3 reset = 1'b0;

    mb[0] = 20;
    send(1, 10, 0);

    for (int i = 0; i < 16; i++) mb[i] = 0;
    send(16, 85, 0);

    for (int i = 0; i < 16; i++) mb[i] = i;
    send(16, 0, 0);

    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 16; i++) begin
        r = 16'($urandom);
        mb[i] = p % 2 == 0 ? longint'(r) : longint'($urandom_range(0, 2000)) - 1000;
      end
      t = 0;
      while (q16.size() > 0 && t < 20000) begin
        @(negedge clk);
        t++;
      end
      held_n = 0;
      dir = p == 0;
      rnd = p >= 2;
      send(16, p == 5 ? int'($urandom_range(1, 85)) : 85, p == 3 ? longint'($urandom_range(0, 8192)) : 0);
      mb[0] = longint'($urandom_range(0, 2000)) - 1000;
      send(1, int'($urandom_range(0, 10)), 0);
    end

    t = 0;
    while (q16.size() > 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    dir = 0;
    rnd = 0;
    for (int i = 0; i < 16; i++) mb[i] = longint'($urandom_range(0, 2000)) - 1000;
    send(16, 85, 0);
    repeat (45) @(negedge clk);
    chk("mid_solve_busy", io16.busy, 1);
    #3 reset = 1'b1;
    #1;
    chk("abort_busy", io16.busy, 0);
    chk("abort_out_valid", io16.out_valid, 0);
    q16.delete();
    sc16.delete();
    q1.delete();
    sc1.delete();
    @(negedge clk);
    check_idle();
    #3 reset = 1'b0;
    mb[0] = 20;
    send(1, 10, 0);
    for (int i = 0; i < 16; i++) mb[i] = 0;
    send(16, 85, 0);

    t = 0;
    while ((q16.size() > 0 || q1.size() > 0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) chk("drain_timeout", q16.size() + q1.size(), 0);
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
